// File: rtl/monolith_pkg.sv
// Shared definitions for the Monolith concrete-layer controller:
// M31 prime, controller state encoding and the field-word type.
package monolith_pkg;

  // Width of one M31 field element and the prime 2^31-1.
  localparam int unsigned M31_WIDTH = 31;
  localparam logic [31:0] M31_P     = 32'h7FFF_FFFF;

  // One M31 field element.
  typedef logic [M31_WIDTH-1:0] word_t;

  // LOAD: collect the input vector; RUN: wait for the multiplier;
  // DRAIN: stream the captured result out.
  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/m31_rc_add.sv
// Combinational M31 modular adder: sum = (a + b) mod (2^31-1).
// Both operands are expected to be already reduced (< P), so one
// conditional subtraction is enough.
module m31_rc_add
  import monolith_pkg::*;
#(
  parameter int WORD_WIDTH = 31
) (
  input  logic [WORD_WIDTH-1:0] a,
  input  logic [WORD_WIDTH-1:0] b,
  output logic [WORD_WIDTH-1:0] sum
);

  localparam logic [WORD_WIDTH:0] P_EXT = (WORD_WIDTH + 1)'(M31_P);

  logic [WORD_WIDTH:0] raw;

  // Widen by one bit so the carry is kept, then fold back once.
  always_comb begin
    raw = {1'b0, a} + {1'b0, b};
    sum = WORD_WIDTH'((raw >= P_EXT) ? (raw - P_EXT) : raw);
  end

endmodule

// File: rtl/concrete_layer_ctrl.sv
// Concrete-layer controller for a Monolith-style permutation.
// Loads a state vector serially, holds it on mul_vec for an external
// circulant multiplier, captures the multiplier result and streams it
// back out serially.
// Optional feature: define CONCRETE_RC_EN to add an rc port and fold
// the round constants into each captured word (mod 2^31-1).
module concrete_layer_ctrl
  import monolith_pkg::*;
#(
  parameter int WORD_WIDTH = 31,
  parameter int MTX_SIZE   = 16
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [WORD_WIDTH-1:0]               in_data,
  output logic [MTX_SIZE-1:0][WORD_WIDTH-1:0] mul_vec,
  output logic                                mul_reset,
  input  logic [MTX_SIZE-1:0][WORD_WIDTH-1:0] mul_result,
  input  logic                                mul_valid,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [WORD_WIDTH-1:0]               out_data,
  output logic                                out_last
`ifdef CONCRETE_RC_EN
  ,
  input  logic [MTX_SIZE-1:0][WORD_WIDTH-1:0] rc
`endif
);

  localparam int unsigned           IDX_W    = $clog2(MTX_SIZE);
  localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(MTX_SIZE - 1);

  state_t                                state;
  state_t                                state_next;
  logic [IDX_W-1:0]                      wr_idx;
  logic [IDX_W-1:0]                      rd_idx;
  logic [MTX_SIZE-1:0][WORD_WIDTH-1:0]   vec_buf;
  logic [MTX_SIZE-1:0][WORD_WIDTH-1:0]   res_buf;
  logic [MTX_SIZE-1:0][WORD_WIDTH-1:0]   cap_word;
  // High during the first RUN cycle, while the multiplier is still
  // leaving reset and its valid cannot be trusted.
  logic                                  run_first;
  logic                                  load_fire;
  logic                                  load_done;
  logic                                  capture;
  logic                                  drain_fire;

  // Value written into res_buf on capture.
`ifdef CONCRETE_RC_EN
  for (genvar k = 0; k < MTX_SIZE; k++) begin : g_rc_add
    m31_rc_add #(
      .WORD_WIDTH (WORD_WIDTH)
    ) u_rc_add (
      .a   (mul_result[k]),
      .b   (rc[k]),
      .sum (cap_word[k])
    );
  end
`else
  assign cap_word = mul_result;
`endif

  // The multiplier sees the held input vector directly.
  assign mul_vec = vec_buf;

  // State register.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= LOAD;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and output decode.
  // NOTE: every output gets a default first, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    mul_reset  = 1'b0;
    out_valid  = 1'b0;
    out_last   = 1'b0;
    out_data   = '0;
    load_fire  = 1'b0;
    load_done  = 1'b0;
    capture    = 1'b0;
    drain_fire = 1'b0;
    unique case (state)
      LOAD: begin
        in_ready  = 1'b1;
        mul_reset = 1'b1;
        load_fire = in_valid;
        load_done = in_valid && (wr_idx == LAST_IDX);
        if (load_done) state_next = RUN;
      end
      RUN: begin
        capture = mul_valid && !run_first;
        if (capture) state_next = DRAIN;
      end
      DRAIN: begin
        mul_reset  = 1'b1;
        out_valid  = 1'b1;
        out_data   = res_buf[rd_idx];
        out_last   = (rd_idx == LAST_IDX);
        drain_fire = out_ready;
        if (out_ready && out_last) state_next = LOAD;
      end
      default: state_next = LOAD;
    endcase
  end

  // Datapath: vector/result buffers, indices and the first-RUN flag.
  // NOTE: the buffers are reset here because mul_vec and out_data must
  // read as zero during reset; plain storage arrays would not be.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_idx    <= '0;
      rd_idx    <= '0;
      vec_buf   <= '0;
      res_buf   <= '0;
      run_first <= 1'b0;
    end else begin
      run_first <= load_done;
      if (load_fire) begin
        vec_buf[wr_idx] <= in_data;
        wr_idx          <= load_done ? '0 : wr_idx + 1'b1;
      end
      if (capture) begin
        res_buf <= cap_word;
      end
      if (drain_fire) begin
        rd_idx <= out_last ? '0 : rd_idx + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_concrete_layer_ctrl.sv
// Scoreboard bench for concrete_layer_ctrl. Expected output words are
// queued when a vector finishes loading; a negedge monitor pops and
// compares on every output handshake and checks stability on stalls.
// Honours CONCRETE_RC_EN the same way as the design.
module tb_concrete_layer_ctrl;

  localparam int          W = 31;
  localparam int          N = 16;
  localparam logic [63:0] P = 64'h7FFF_FFFF;

  typedef struct packed {
    logic [W-1:0] data;
    logic         last;
  } exp_t;

  logic                clk = 1'b0;
  logic                reset;
  logic                in_valid;
  logic                in_ready;
  logic [W-1:0]        in_data;
  logic [N-1:0][W-1:0] mul_vec;
  logic                mul_reset;
  logic [N-1:0][W-1:0] mul_result;
  logic                mul_valid;
  logic                out_valid;
  logic                out_ready;
  logic [W-1:0]        out_data;
  logic                out_last;
`ifdef CONCRETE_RC_EN
  logic [N-1:0][W-1:0] rc;
`endif

  exp_t         sb[$];
  int           total   = 0;
  int           bad     = 0;
  int           popped  = 0;
  int           pushed  = 0;
  int           flushed = 0;
  logic [W-1:0] stim[N];

  always #5 clk = ~clk;

  concrete_layer_ctrl #(
    .WORD_WIDTH (W),
    .MTX_SIZE   (N)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .mul_vec    (mul_vec),
    .mul_reset  (mul_reset),
    .mul_result (mul_result),
    .mul_valid  (mul_valid),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last)
`ifdef CONCRETE_RC_EN
    ,
    .rc         (rc)
`endif
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] exp_word(input int k);
`ifdef CONCRETE_RC_EN
    logic [63:0] s;
    s = (64'(mul_result[k]) + 64'(rc[k])) % P;
    return s[W-1:0];
`else
    return mul_result[k];
`endif
  endfunction

  task automatic push_expect();
    for (int k = 0; k < N; k++) begin
      sb.push_back('{data: exp_word(k), last: (k == N - 1)});
      pushed++;
    end
  endtask

  task automatic set_stim(input int base);
    for (int k = 0; k < N; k++) stim[k] = W'(base + k);
  endtask

  task automatic set_result(input int base);
    for (int k = 0; k < N; k++) mul_result[k] = W'(base + 17 * k);
  endtask

  // Drives n words back-to-back; returns 1 ns after the last acceptance edge.
  task automatic load_n(input int n);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_data  = stim[i];
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_data  = '0;
  endtask

  task automatic check_vec(input string name);
    int miss = 0;
    for (int k = 0; k < N; k++) if (mul_vec[k] !== stim[k]) miss++;
    check(name, miss, 0);
  endtask

  // Cycles from the final acceptance edge to out_valid (-1 on timeout).
  task automatic wait_out_valid(output int lat);
    lat = -1;
    for (int i = 1; i <= 50; i++) begin
      @(posedge clk); #1;
      if (out_valid) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic wait_idle(input string name);
    int ok = 0;
    for (int i = 0; i < 200; i++) begin
      if (in_ready) begin
        ok = 1;
        break;
      end
      @(posedge clk); #1;
    end
    check(name, ok, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"},  in_ready,          1);
    check({tag, "_mul_reset"}, mul_reset,         1);
    check({tag, "_out_valid"}, out_valid,         0);
    check({tag, "_out_last"},  out_last,          0);
    check({tag, "_out_data"},  out_data,          0);
    check({tag, "_mul_vec"},   (mul_vec == '0),   1);
  endtask

  // Monitor: compares each handshaken word and holds stalled outputs steady.
  logic         stall_prev = 1'b0;
  logic [W-1:0] data_prev;
  logic         last_prev;
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev && out_valid) begin
        check("stall_data", out_data, data_prev);
        check("stall_last", out_last, last_prev);
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_out", sb.size(), 1);
        end else begin
          e = sb.pop_front();
          check("out_data", out_data, e.data);
          check("out_last", out_last, e.last);
          popped++;
        end
      end
      stall_prev = out_valid && !out_ready;
      data_prev  = out_data;
      last_prev  = out_last;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   lat;
    int   early;
    int   seen_last;
    logic hs_last;
    int   pat[4] = '{1, 0, 0, 1};

    reset      = 1'b1;
    in_valid   = 1'b0;
    in_data    = '0;
    mul_valid  = 1'b0;
    out_ready  = 1'b0;
    mul_result = '0;
`ifdef CONCRETE_RC_EN
    rc         = '0;
`endif
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    reset = 1'b0;
    @(posedge clk); #1;

    // Words 1..16, mul_valid tied high, sink always ready.
    set_stim(1);
    set_result(1000);
    mul_valid = 1'b1;
    out_ready = 1'b1;
    load_n(N);
    push_expect();
    check("t1_in_ready_low", in_ready, 0);
    wait_out_valid(lat);
    check("t1_latency", lat, 2);
    check_vec("t1_mul_vec");
    wait_idle("t1_back_to_load");
    check("t1_sb_empty", sb.size(), 0);

    // mul_valid high in the first RUN cycle, then low for 5 cycles.
    set_stim(20);
    set_result(2000);
    load_n(N);
    push_expect();
    lat = -1;
    for (int i = 1; i <= 50; i++) begin
      @(posedge clk); #1;
      if (out_valid) begin
        lat = i;
        break;
      end
      mul_valid = (i >= 6);
    end
    check("t2_latency", lat, 7);
    wait_idle("t2_back_to_load");
    check("t2_sb_empty", sb.size(), 0);

    // out_ready pattern 1,0,0,1 during drain.
    set_stim(50);
    set_result(3000);
    mul_valid = 1'b1;
    out_ready = 1'b0;
    load_n(N);
    push_expect();
    wait_out_valid(lat);
    check("t3_latency", lat, 2);
    early     = 0;
    seen_last = 0;
    for (int c = 0; c < 200 && seen_last == 0; c++) begin
      out_ready = pat[c % 4][0];
      @(negedge clk);
      hs_last = out_valid && out_ready && out_last;
      @(posedge clk); #1;
      if (hs_last) seen_last = 1;
      else if (in_ready) early++;
    end
    check("t3_last_seen", seen_last, 1);
    check("t3_no_early_load", early, 0);
    check("t3_load_after_last", in_ready, 1);
    check("t3_sb_empty", sb.size(), 0);
    out_ready = 1'b1;

    // Reset after 9 words, then a fresh full load.
    set_stim(100);
    load_n(9);
    #2 reset = 1'b1;
    #1 check_reset_outputs("t4_mid_load");
    @(posedge clk); #1;
    reset = 1'b0;
    set_stim(200);
    set_result(4000);
    load_n(N);
    push_expect();
    wait_out_valid(lat);
    check("t4_latency", lat, 2);
    check_vec("t4_mul_vec");
    wait_idle("t4_back_to_load");

    // Reset in the middle of a stalled drain.
    set_stim(250);
    out_ready = 1'b0;
    load_n(N);
    push_expect();
    wait_out_valid(lat);
    check("t4d_latency", lat, 2);
    #2 reset = 1'b1;
    #1 check_reset_outputs("t4_mid_drain");
    flushed += sb.size();
    sb.delete();
    @(posedge clk); #1;
    reset     = 1'b0;
    out_ready = 1'b1;

`ifdef CONCRETE_RC_EN
    // Round-constant modular addition corner cases.
    set_stim(260);
    for (int k = 0; k < N; k++) begin
      mul_result[k] = W'(k + 10);
      rc[k]         = W'(k + 1);
    end
    mul_result[0] = 31'h7FFF_FFFE;
    rc[0]         = 31'd5;
    mul_result[1] = 31'd3;
    rc[1]         = 31'h7FFF_FFFC;
    out_ready     = 1'b0;
    load_n(N);
    push_expect();
    wait_out_valid(lat);
    check("t5_latency", lat, 2);
    check("t5_rc_word0", out_data, 4);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("t5_rc_word1", out_data, 0);
    out_ready = 1'b1;
    wait_idle("t5_back_to_load");
    check("t5_sb_empty", sb.size(), 0);
`endif

    // in_valid pulsed during RUN and a stalled DRAIN is ignored.
    set_stim(300);
    set_result(5000);
    mul_valid = 1'b0;
    out_ready = 1'b0;
    load_n(N);
    push_expect();
    in_valid = 1'b1;
    in_data  = 31'h1234;
    repeat (3) @(posedge clk);
    #1;
    check_vec("t6_vec_run");
    mul_valid = 1'b1;
    wait_out_valid(lat);
    check("t6_reached_drain", lat > 0, 1);
    repeat (3) @(posedge clk);
    #1;
    check_vec("t6_vec_drain");
    check("t6_in_ready_drain", in_ready, 0);
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    wait_idle("t6_back_to_load");
    set_stim(400);
    set_result(6000);
    load_n(N);
    push_expect();
    wait_out_valid(lat);
    check("t6_next_latency", lat, 2);
    check_vec("t6_next_vec");
    wait_idle("t6_next_back_to_load");

    repeat (2) @(posedge clk);
    #1;
    check("final_sb_empty", sb.size(), 0);
    check("final_words_popped", popped, pushed - flushed);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
